// File: rtl/sram_bank_pkg.sv
// Shared types and helpers for the self-sequenced SRAM bank.
// Phase vectors are built at a fixed maximum width and cast down by the user.
package sram_bank_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MAX_NPHASE = 64;

    typedef logic [MAX_NPHASE-1:0] phase_vec_t;

    // Width of a counter that can index n phases.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic phase_vec_t onehot(input int idx, input int n);
        phase_vec_t v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_NPHASE) begin
            v = phase_vec_t'(1'b1) << idx;
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/sram_phase_seq.sv
// Operation sequencer: IDLE/RUN FSM, one-hot phase generator and the
// handshake, done and read/write strobes derived from it.
module sram_phase_seq
    import sram_bank_pkg::*;
#(
    parameter int NPHASE   = 10,
    parameter int READ_PH  = 6,
    parameter int WRITE_PH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    output logic              o_accept,
    output logic [NPHASE-1:0] o_phase,
    output logic              o_done,
    output logic              o_rd_stb,
    output logic              o_wr_stb
);

    localparam int CW = cnt_w(NPHASE);
    localparam logic [CW-1:0] LAST = CW'(NPHASE - 1);

    if (!(READ_PH > 0 && READ_PH < WRITE_PH && WRITE_PH < NPHASE && NPHASE <= MAX_NPHASE)) begin : g_bad_cfg
        $error("sram_phase_seq: need 0 < READ_PH < WRITE_PH < NPHASE <= MAX_NPHASE");
    end

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [NPHASE-1:0] r_phase;
    logic [NPHASE-1:0] w_phase_nxt;
    logic              w_ready;
    logic              w_accept;

    // The last phase also accepts, so ops chain without an idle bubble.
    assign w_ready  = (r_state == IDLE) || r_phase[NPHASE-1];
    assign w_accept = i_op_valid && w_ready;

    // Next-state and next-phase logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = RUN;
                    w_phase_nxt = NPHASE'(onehot(0, NPHASE));
                end else begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = '0;
                end
            end
            RUN: begin
                if (r_cnt != LAST) begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_phase_nxt = NPHASE'(onehot(int'(r_cnt) + 1, NPHASE));
                end else if (w_accept) begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = NPHASE'(onehot(0, NPHASE));
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_phase_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_phase_nxt = '0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign o_op_ready = w_ready;
    assign o_accept   = w_accept;
    assign o_phase    = r_phase;
    assign o_done     = r_phase[NPHASE-1];
    assign o_rd_stb   = r_phase[READ_PH];
    assign o_wr_stb   = r_phase[WRITE_PH];

endmodule

// File: rtl/sram_bank_seq.sv
// Self-sequenced SRAM bank with NREAD read ports and one masked write port;
// each op reads in phase READ_PH and commits its write in phase WRITE_PH.
module sram_bank_seq
    import sram_bank_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 32,
    parameter  int NREAD    = 2,
    parameter  int NPHASE   = 10,
    parameter  int READ_PH  = 6,
    parameter  int WRITE_PH = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic                   op_rd,
    input  logic                   op_wr,
    input  logic [NREAD*AW-1:0]    raddr,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [WIDTH-1:0]       wmask,
    output logic [NREAD*WIDTH-1:0] rdata,
    output logic                   rvalid,
    output logic                   done,
    output logic                   addr_err,
    output logic [NPHASE-1:0]      phase
);

    if (NREAD < 1) begin : g_bad_nread
        $error("sram_bank_seq: NREAD must be at least 1");
    end

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic                   r_op_rd;
    logic                   r_op_wr;
    logic [NREAD*AW-1:0]    r_raddr;
    logic [AW-1:0]          r_waddr;
    logic [WIDTH-1:0]       r_wdata;
    logic [WIDTH-1:0]       r_wmask;
    logic [NREAD*WIDTH-1:0] r_rdata;
    logic                   r_rvalid;
    logic                   r_addr_err;

    logic                   w_accept;
    logic                   w_rd_stb;
    logic                   w_wr_stb;
    logic                   w_err_now;
    logic [NREAD*WIDTH-1:0] w_rdata_nxt;
    logic [WIDTH-1:0]       w_wmerge;
    logic                   w_wr_en;

    sram_phase_seq #(
        .NPHASE   (NPHASE),
        .READ_PH  (READ_PH),
        .WRITE_PH (WRITE_PH)
    ) u_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_op_valid (op_valid),
        .o_op_ready (op_ready),
        .o_accept   (w_accept),
        .o_phase    (phase),
        .o_done     (done),
        .o_rd_stb   (w_rd_stb),
        .o_wr_stb   (w_wr_stb)
    );

    // Range check of the addresses an incoming op will actually use.
    always_comb begin
        w_err_now = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            w_err_now = w_err_now | (op_rd && ({1'b0, raddr[p*AW +: AW]} >= DEPTH_V));
        end
        w_err_now = w_err_now | (op_wr && ({1'b0, waddr} >= DEPTH_V));
    end

    // Read-port muxing; an out-of-range port reads as zero.
    always_comb begin
        w_rdata_nxt = '0;
        for (int p = 0; p < NREAD; p++) begin
            if ({1'b0, r_raddr[p*AW +: AW]} < DEPTH_V) begin
                w_rdata_nxt[p*WIDTH +: WIDTH] = r_mem[r_raddr[p*AW +: AW]];
            end else begin
                w_rdata_nxt[p*WIDTH +: WIDTH] = '0;
            end
        end
    end

    assign w_wmerge = (r_mem[r_waddr] & ~r_wmask) | (r_wdata & r_wmask);
    assign w_wr_en  = w_wr_stb && r_op_wr && ({1'b0, r_waddr} < DEPTH_V);

    // Storage array: deliberately no reset, contents survive reset_n.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_waddr] <= w_wmerge;
        end
    end

    // Holding registers captured on the accept edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_rd <= 1'b0;
            r_op_wr <= 1'b0;
            r_raddr <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_op_rd <= op_rd;
            r_op_wr <= op_wr;
            r_raddr <= raddr;
            r_waddr <= waddr;
            r_wdata <= wdata;
            r_wmask <= wmask;
        end
    end

    // Read data, read-valid pulse and sticky address error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rvalid   <= w_rd_stb && r_op_rd;
            r_addr_err <= r_addr_err | (w_accept && w_err_now);
            if (w_rd_stb && r_op_rd) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_sram_bank_seq.sv
// Scoreboard bench: two banks (DEPTH 32 and DEPTH 20) share one stimulus
// stream; a small reference model predicts phases, strobes and read data.
module tb_sram_bank_seq;

    localparam int NPH = 10;
    localparam int RPH = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_rd = 1'b0;
    logic        op_wr = 1'b0;
    logic [9:0]  raddr = '0;
    logic [4:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] wmask = '0;

    logic        a_ready, a_rvalid, a_done, a_err;
    logic [31:0] a_rdata;
    logic [9:0]  a_phase;
    logic        b_ready, b_rvalid, b_done, b_err;
    logic [31:0] b_rdata;
    logic [9:0]  b_phase;

    sram_bank_seq u_a (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(a_ready),
        .op_rd(op_rd), .op_wr(op_wr), .raddr(raddr), .waddr(waddr),
        .wdata(wdata), .wmask(wmask), .rdata(a_rdata), .rvalid(a_rvalid),
        .done(a_done), .addr_err(a_err), .phase(a_phase)
    );

    sram_bank_seq #(.DEPTH(20)) u_b (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(b_ready),
        .op_rd(op_rd), .op_wr(op_wr), .raddr(raddr), .waddr(waddr),
        .wdata(wdata), .wmask(wmask), .rdata(b_rdata), .rvalid(b_rvalid),
        .done(b_done), .addr_err(b_err), .phase(b_phase)
    );

    always #5 clk = ~clk;

    typedef struct { int acc; bit rd; } op_t;
    typedef struct { logic [31:0] ea; logic [31:0] eb; } rd_t;

    op_t         acc_q[$];
    rd_t         sb_q[$];
    logic [15:0] mem_a [32];
    logic [15:0] mem_b [20];
    bit          err_b = 1'b0;
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ma(input logic [4:0] a);
        return mem_a[a];
    endfunction

    function automatic logic [15:0] mb(input logic [4:0] a);
        return (a < 5'd20) ? mem_b[a] : 16'h0000;
    endfunction

    // Per-cycle model of phase, done, ready, rvalid plus read-data scoreboard.
    always @(negedge clk) begin : mon
        logic [9:0] e_ph;
        bit         e_rv;
        int         k;
        rd_t        ent;
        if (mon_en) begin
            e_ph = '0;
            e_rv = 1'b0;
            foreach (acc_q[i]) begin
                k = cyc - acc_q[i].acc - 1;
                if (k >= 0 && k < NPH) e_ph = e_ph | (10'd1 << k);
                if (acc_q[i].rd && k == RPH + 1) e_rv = 1'b1;
            end
            check_eq("a_phase", {22'd0, a_phase}, {22'd0, e_ph});
            check_eq("b_phase", {22'd0, b_phase}, {22'd0, e_ph});
            check_eq("a_done", {31'd0, a_done}, {31'd0, e_ph[NPH-1]});
            check_eq("a_ready", {31'd0, a_ready}, {31'd0, (e_ph == 10'd0) || e_ph[NPH-1]});
            check_eq("b_ready", {31'd0, b_ready}, {31'd0, (e_ph == 10'd0) || e_ph[NPH-1]});
            check_eq("a_rvalid", {31'd0, a_rvalid}, {31'd0, e_rv});
            check_eq("b_rvalid", {31'd0, b_rvalid}, {31'd0, e_rv});
            if (a_rvalid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    ent = sb_q.pop_front();
                    check_eq("a_rdata", a_rdata, ent.ea);
                    check_eq("b_rdata", b_rdata, ent.eb);
                end
            end
        end
    end

    task automatic do_op(input bit rd, input bit wr, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [4:0] wa, input logic [15:0] wd, input logic [15:0] wm,
                         input bit commit);
        int  n;
        op_t o;
        rd_t r;
        n = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_rd = rd; op_wr = wr;
        raddr = {ra1, ra0}; waddr = wa; wdata = wd; wmask = wm;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("ready_timeout", {31'd0, a_ready}, 32'd1);
        o.acc = cyc;
        o.rd  = rd;
        acc_q.push_back(o);
        if (rd) begin
            r.ea = {ma(ra1), ma(ra0)};
            r.eb = {mb(ra1), mb(ra0)};
            sb_q.push_back(r);
            if (ra0 >= 5'd20 || ra1 >= 5'd20) err_b = 1'b1;
        end
        if (wr) begin
            if (wa >= 5'd20) err_b = 1'b1;
            if (commit) begin
                mem_a[wa] = (mem_a[wa] & ~wm) | (wd & wm);
                if (wa < 5'd20) mem_b[wa] = (mem_b[wa] & ~wm) | (wd & wm);
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_a_outs"}, {a_phase, a_rvalid, a_done, a_err, a_ready}, {10'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        check_eq({tag, "_b_outs"}, {b_phase, b_rvalid, b_done, b_err, b_ready}, {10'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        check_eq({tag, "_a_rdata"}, a_rdata, 32'd0);
        check_eq({tag, "_b_rdata"}, b_rdata, 32'd0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        #2 reset_n = 1'b1;
        mon_en = 1'b1;

        // Preload; address 31 and 25 are out of range for the 20-word bank.
        do_op(0, 1, 5'd0, 5'd0, 5'd31, 16'h5555, 16'hFFFF, 1);
        do_op(0, 1, 5'd0, 5'd0, 5'd1,  16'hAAAA, 16'hFFFF, 1);
        do_op(0, 1, 5'd0, 5'd0, 5'd2,  16'h1234, 16'hFFFF, 1);
        do_op(0, 1, 5'd0, 5'd0, 5'd5,  16'h0F0F, 16'hFFFF, 1);
        do_op(0, 1, 5'd0, 5'd0, 5'd25, 16'h2525, 16'hFFFF, 1);
        do_op(0, 1, 5'd0, 5'd0, 5'd3,  16'h3333, 16'hFFFF, 1);
        idle(12);

        // Basic read of two ports.
        do_op(1, 0, 5'd1, 5'd31, 5'd0, 16'h0000, 16'h0000, 1);
        idle(12);
        check_eq("t1_a_err", {31'd0, a_err}, 32'd0);
        check_eq("t1_b_err", {31'd0, b_err}, {31'd0, err_b});

        // Masked write then read back.
        do_op(0, 1, 5'd0, 5'd0, 5'd2, 16'hABCD, 16'h00FF, 1);
        do_op(1, 0, 5'd2, 5'd1, 5'd0, 16'h0000, 16'h0000, 1);
        idle(12);

        // Read-before-write inside one op, new data on the next op.
        do_op(1, 1, 5'd5, 5'd5, 5'd5, 16'hF0F0, 16'hFFFF, 1);
        do_op(1, 0, 5'd5, 5'd2, 5'd0, 16'h0000, 16'h0000, 1);
        idle(12);

        // Back-to-back ops, including an op that neither reads nor writes.
        do_op(1, 0, 5'd1, 5'd2, 5'd0, 16'h0000, 16'h0000, 1);
        do_op(1, 0, 5'd5, 5'd1, 5'd0, 16'h0000, 16'h0000, 1);
        do_op(0, 0, 5'd0, 5'd0, 5'd0, 16'h0000, 16'h0000, 1);
        idle(12);

        // Out-of-range read and write.
        do_op(1, 1, 5'd25, 5'd1, 5'd31, 16'h0000, 16'hFFFF, 1);
        do_op(1, 0, 5'd31, 5'd2, 5'd0, 16'h0000, 16'h0000, 1);
        idle(12);
        check_eq("t5_a_err", {31'd0, a_err}, 32'd0);
        check_eq("t5_b_err", {31'd0, b_err}, {31'd0, err_b});

        // Reset during phase 7 of a write: the write must not land.
        do_op(0, 1, 5'd0, 5'd0, 5'd3, 16'hDEAD, 16'hFFFF, 0);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("t6_phase7", {22'd0, a_phase}, 32'h0000_0080);
        #2 reset_n = 1'b0;
        acc_q.delete();
        sb_q.delete();
        err_b = 1'b0;
        #1 check_reset_outs("t6_reset");
        @(negedge clk);
        #2 reset_n = 1'b1;
        do_op(1, 0, 5'd3, 5'd1, 5'd0, 16'h0000, 16'h0000, 1);
        idle(12);
        check_eq("t6_b_err", {31'd0, b_err}, 32'd0);

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
